// File: rtl/load_unit.sv
// Data-memory load path: alignment check, one word-aligned bus read with
// request/acknowledge and timeout, then byte/halfword/word extraction and extension.
module load_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_valid,
    output logic        O_ready,
    input  logic [2:0]  I_loadsel,
    input  logic [31:0] I_addr,
    output logic        O_bus_req,
    output logic [31:0] O_bus_addr,
    input  logic        I_bus_ack,
    input  logic [31:0] I_bus_data,
    output logic        O_valid,
    output logic [31:0] O_data,
    output logic        O_err,
    output logic        O_misaligned,
    output logic [1:0]  O_state
);

    // Handshakes: a request transfers on a rising edge where I_valid & O_ready;
    // a bus read completes on a rising edge where O_bus_req & I_bus_ack.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;

    function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] lo);
        case (sel)
            3'b000, 3'b100: is_misaligned = 1'b0;
            3'b001, 3'b101: is_misaligned = lo[0];
            default:        is_misaligned = (lo != 2'b00);
        endcase
    endfunction

    function automatic logic [31:0] format_word(input logic [2:0] sel, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {lo, 3'b000};
        b = shifted[7:0];
        h = lo[1] ? word[31:16] : word[15:0];
        case (sel)
            3'b000:  format_word = {{24{b[7]}}, b};
            3'b100:  format_word = {24'b0, b};
            3'b001:  format_word = {{16{h[15]}}, h};
            3'b101:  format_word = {16'b0, h};
            default: format_word = word;
        endcase
    endfunction

    always_ff @(posedge I_clk) begin
        if (!I_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            sel_q   <= 3'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        mis_d   = mis_q;
        case (state_q)
            S_IDLE: begin
                if (I_valid) begin
                    sel_d  = I_loadsel;
                    addr_d = I_addr;
                    cnt_d  = 8'd0;
                    if (is_misaligned(I_loadsel, I_addr[1:0])) begin
                        data_d  = 32'd0;
                        err_d   = 1'b1;
                        mis_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // An ack in the final allowed cycle still completes normally.
                if (I_bus_ack) begin
                    data_d  = format_word(sel_q, addr_q[1:0], I_bus_data);
                    err_d   = 1'b0;
                    mis_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == LAST_WAIT) begin
                    data_d  = 32'd0;
                    err_d   = 1'b1;
                    mis_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        O_ready      = (state_q == S_IDLE);
        O_bus_req    = (state_q == S_WAIT);
        O_valid      = (state_q == S_DONE);
        O_bus_addr   = {addr_q[31:2], 2'b00};
        O_data       = data_q;
        O_err        = err_q;
        O_misaligned = mis_q;
        O_state      = state_q;
    end

endmodule
